// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: merges the CPU instruction-fetch and data-access ports
// onto one shared valid/ready memory bus, one transaction in flight at a time.
// The data port wins ties; the instruction port is forced through after
// STARVE_LIMIT consecutive data grants while it waits.
module sram_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_done,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_done,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [3:0]  bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q;
    logic        owner_q;        // 1 = data port owns the transaction
    logic [3:0]  starve_cnt_q;
    logic [3:0]  starve_cnt_d;
    logic        bus_req_valid_q;
    logic [3:0]  bus_wen_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] inst_rdata_q;
    logic        inst_done_q;
    logic [31:0] data_rdata_q;
    logic        data_done_q;
    logic        grant_inst;
    logic        grant_data;

    // Arbitration decision and the starvation counter update it implies.
    always_comb begin
        grant_inst   = inst_req && (!data_req || (starve_cnt_q == LIMIT));
        grant_data   = !grant_inst && data_req;
        starve_cnt_d = '0;
        if (grant_data && inst_req) begin
            starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_q         <= 1'b0;
            starve_cnt_q    <= '0;
            bus_req_valid_q <= 1'b0;
            bus_wen_q       <= '0;
            bus_addr_q      <= '0;
            bus_wdata_q     <= '0;
            inst_rdata_q    <= '0;
            inst_done_q     <= 1'b0;
            data_rdata_q    <= '0;
            data_done_q     <= 1'b0;
        end else begin
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_inst || grant_data) begin
                        owner_q         <= grant_data;
                        bus_addr_q      <= grant_data ? data_addr : inst_addr;
                        bus_wen_q       <= grant_data ? data_wen : 4'h0;
                        bus_wdata_q     <= grant_data ? data_wdata : 32'h0;
                        bus_req_valid_q <= 1'b1;
                        starve_cnt_q    <= starve_cnt_d;
                        state_q         <= REQ;
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid_q <= 1'b0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_resp_valid) begin
                        if (owner_q) begin
                            // A store has no read data; report zero instead.
                            data_rdata_q <= (bus_wen_q != 4'h0) ? 32'h0 : bus_rdata;
                            data_done_q  <= 1'b1;
                        end else begin
                            inst_rdata_q <= bus_rdata;
                            inst_done_q  <= 1'b1;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // No arbitration here: the core updates its request on this edge.
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_req_valid = bus_req_valid_q;
    assign bus_wen       = bus_wen_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign inst_rdata    = inst_rdata_q;
    assign inst_done     = inst_done_q;
    assign data_rdata    = data_rdata_q;
    assign data_done     = data_done_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard testbench for sram_bus_arbiter: directed transactions push their
// expected bus requests and completions into queues; monitors pop and compare.
module tb_sram_bus_arbiter;

    typedef struct packed {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } done_t;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    bus_t        exp_bus_q[$];
    done_t       exp_done_q[$];
    logic [31:0] inst_ops[$];
    bus_t        data_ops[$];
    logic [31:0] resp_q[$];
    int          done_cyc[$];

    int stall_cycles = 0;
    int resp_delay   = 0;
    bit resp_pending = 0;
    int resp_cnt     = 0;

    logic [31:0] mdl_inst_rdata = '0;
    logic [31:0] mdl_data_rdata = '0;
    logic        prev_v = 1'b0;
    bus_t        held;

    sram_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_rdata     (inst_rdata),
        .inst_done      (inst_done),
        .data_req       (data_req),
        .data_wen       (data_wen),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_rdata     (data_rdata),
        .data_done      (data_done),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_wen        (bus_wen),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_resp_valid (bus_resp_valid),
        .bus_rdata      (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkbus(input string name, input bus_t act, input bus_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got wen=%h addr=%h wdata=%h expected wen=%h addr=%h wdata=%h",
                     name, act.wen, act.addr, act.wdata, exp.wen, exp.addr, exp.wdata);
        end
    endtask

    // Bus slave: accepts requests (optionally after a stall with spurious
    // response strobes), then answers after resp_delay extra cycles.
    initial begin
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_rdata      = '0;
        forever begin
            @(negedge clk);
            bus_req_ready  = 1'b0;
            bus_resp_valid = 1'b0;
            if (rst) begin
                resp_pending = 0;
                resp_cnt     = 0;
            end else if (resp_pending) begin
                if (resp_cnt < resp_delay) begin
                    resp_cnt++;
                end else begin
                    bus_resp_valid = 1'b1;
                    bus_rdata      = (resp_q.size() > 0) ? resp_q.pop_front() : 32'hEEEEEEEE;
                    resp_pending   = 0;
                    resp_cnt       = 0;
                end
            end else if (bus_req_valid) begin
                if (stall_cycles > 0) begin
                    stall_cycles--;
                    bus_resp_valid = 1'b1;
                    bus_rdata      = 32'h5A5A5A5A;
                end else begin
                    bus_req_ready = 1'b1;
                    resp_pending  = 1;
                end
            end
        end
    end

    // Completion monitor: each done pulse is matched against the next expectation.
    always @(negedge clk) begin
        done_t e;
        if (rst) begin
            mdl_inst_rdata = '0;
            mdl_data_rdata = '0;
        end else if (inst_done || data_done) begin
            if (exp_done_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got inst_done=%0b data_done=%0b required none",
                         inst_done, data_done);
            end else begin
                e = exp_done_q.pop_front();
                check32("done_side", {30'h0, inst_done, data_done}, e.is_data ? 32'h1 : 32'h2);
                if (e.is_data) mdl_data_rdata = e.rdata;
                else           mdl_inst_rdata = e.rdata;
                check32("inst_rdata", inst_rdata, mdl_inst_rdata);
                check32("data_rdata", data_rdata, mdl_data_rdata);
            end
        end
    end

    // Bus request monitor: new requests match expectations; held requests stay stable.
    always @(negedge clk) begin
        bus_t cur;
        cur = {bus_wen, bus_addr, bus_wdata};
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (bus_req_valid && !prev_v) begin
                if (exp_bus_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_bus_req: got addr=%h required none", bus_addr);
                end else begin
                    checkbus("bus_req", cur, exp_bus_q.pop_front());
                end
                held = cur;
            end else if (bus_req_valid && prev_v) begin
                checkbus("bus_req_stable", cur, held);
            end
            prev_v = bus_req_valid;
        end
    end

    // Core model; must be called right after a negedge. Requests are held until
    // done, then replaced by the next queued operation or dropped.
    task automatic run(input int max_cyc);
        int n;
        n = 0;
        done_cyc.delete();
        if (inst_ops.size() > 0) begin
            inst_req  = 1'b1;
            inst_addr = inst_ops.pop_front();
        end
        if (data_ops.size() > 0) begin
            data_req = 1'b1;
            {data_wen, data_addr, data_wdata} = data_ops.pop_front();
        end
        while ((inst_req || data_req) && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (inst_done) begin
                done_cyc.push_back(n);
                if (inst_ops.size() > 0) inst_addr = inst_ops.pop_front();
                else inst_req = 1'b0;
            end
            if (data_done) begin
                done_cyc.push_back(n);
                if (data_ops.size() > 0) {data_wen, data_addr, data_wdata} = data_ops.pop_front();
                else data_req = 1'b0;
            end
        end
        if (inst_req || data_req) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout: got requests still pending after %0d cycles required completion", n);
            inst_req = 1'b0;
            data_req = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check32({tag, "_bus_req_valid"}, 32'(bus_req_valid), 32'h0);
        check32({tag, "_inst_done"}, 32'(inst_done), 32'h0);
        check32({tag, "_data_done"}, 32'(data_done), 32'h0);
        check32({tag, "_inst_rdata"}, inst_rdata, 32'h0);
        check32({tag, "_data_rdata"}, data_rdata, 32'h0);
        check32({tag, "_bus_addr"}, bus_addr, 32'h0);
        check32({tag, "_bus_wen"}, 32'(bus_wen), 32'h0);
        check32({tag, "_bus_wdata"}, bus_wdata, 32'h0);
    endtask

    initial begin
        bit seq[$];
        int di;
        int ii;
        rst        = 1'b1;
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_req   = 1'b0;
        data_wen   = '0;
        data_addr  = '0;
        data_wdata = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Single fetch
        exp_bus_q.push_back({4'h0, 32'hBFC00000, 32'h0});
        exp_done_q.push_back({1'b0, 32'h3C1DA000});
        resp_q.push_back(32'h3C1DA000);
        inst_ops.push_back(32'hBFC00000);
        @(negedge clk);
        run(20);
        check32("fetch_latency", 32'(done_cyc.size() > 0 ? done_cyc[0] : -1), 32'd3);

        // Store then load
        exp_bus_q.push_back({4'hF, 32'h80001000, 32'hDEADBEEF});
        exp_bus_q.push_back({4'h0, 32'h80001000, 32'h0});
        exp_done_q.push_back({1'b1, 32'h0});
        exp_done_q.push_back({1'b1, 32'hDEADBEEF});
        resp_q.push_back(32'hFFFFFFFF);
        resp_q.push_back(32'hDEADBEEF);
        data_ops.push_back({4'hF, 32'h80001000, 32'hDEADBEEF});
        data_ops.push_back({4'h0, 32'h80001000, 32'h0});
        @(negedge clk);
        run(30);
        check32("store_load_2nd_done", 32'(done_cyc.size() > 1 ? done_cyc[1] : -1), 32'd7);

        // Simultaneous requests: data first, inst four cycles later
        exp_bus_q.push_back({4'h0, 32'h80002000, 32'h0});
        exp_bus_q.push_back({4'h0, 32'hBFC00004, 32'h0});
        exp_done_q.push_back({1'b1, 32'h12345678});
        exp_done_q.push_back({1'b0, 32'h24020001});
        resp_q.push_back(32'h12345678);
        resp_q.push_back(32'h24020001);
        data_ops.push_back({4'h0, 32'h80002000, 32'h0});
        inst_ops.push_back(32'hBFC00004);
        @(negedge clk);
        run(30);
        check32("simul_first_done", 32'(done_cyc.size() > 0 ? done_cyc[0] : -1), 32'd3);
        check32("simul_second_done", 32'(done_cyc.size() > 1 ? done_cyc[1] : -1), 32'd7);

        // Starvation: D D D D I D D D D I D with STARVE_LIMIT=4
        seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 9; k++) data_ops.push_back({4'h0, 32'h80003000 + 32'(k * 4), 32'h0});
        for (int k = 0; k < 2; k++) inst_ops.push_back(32'hBFC00200 + 32'(k * 4));
        di = 0;
        ii = 0;
        foreach (seq[k]) begin
            if (seq[k]) begin
                exp_bus_q.push_back({4'h0, 32'hBFC00200 + 32'(ii * 4), 32'h0});
                exp_done_q.push_back({1'b0, 32'h10000000 + 32'(ii)});
                resp_q.push_back(32'h10000000 + 32'(ii));
                ii++;
            end else begin
                exp_bus_q.push_back({4'h0, 32'h80003000 + 32'(di * 4), 32'h0});
                exp_done_q.push_back({1'b1, 32'hD0000000 + 32'(di)});
                resp_q.push_back(32'hD0000000 + 32'(di));
                di++;
            end
        end
        @(negedge clk);
        run(80);
        check32("starve_last_done", 32'(done_cyc.size() > 10 ? done_cyc[10] : -1), 32'd43);

        // Backpressure: 5 stalled cycles with spurious response strobes
        stall_cycles = 5;
        exp_bus_q.push_back({4'h0, 32'hBFC00010, 32'h0});
        exp_done_q.push_back({1'b0, 32'h11223344});
        resp_q.push_back(32'h11223344);
        inst_ops.push_back(32'hBFC00010);
        @(negedge clk);
        run(30);
        check32("backpressure_latency", 32'(done_cyc.size() > 0 ? done_cyc[0] : -1), 32'd8);

        // Reset while waiting for the response
        resp_delay = 50;
        exp_bus_q.push_back({4'h0, 32'hBFC00100, 32'h0});
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = 32'hBFC00100;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        resp_delay = 0;
        rst = 1'b0;
        exp_bus_q.push_back({4'h0, 32'hBFC00100, 32'h0});
        exp_done_q.push_back({1'b0, 32'hCAFEF00D});
        resp_q.push_back(32'hCAFEF00D);
        inst_ops.push_back(32'hBFC00100);
        run(20);
        check32("post_reset_latency", 32'(done_cyc.size() > 0 ? done_cyc[0] : -1), 32'd3);

        repeat (4) @(negedge clk);
        check32("exp_done_left", 32'(exp_done_q.size()), 32'd0);
        check32("exp_bus_left", 32'(exp_bus_q.size()), 32'd0);
        check32("resp_left", 32'(resp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
